// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage placed directly after the PC register. It issues one
// instruction-memory request at a time for the current PC, waits a variable
// number of cycles for the response and writes {instr, pc, pc+4} into the
// IF/ID pipeline register. The hold_pc output lets the PC advance only when an
// instruction is actually consumed by IF/ID, or when a redirect (flush) is
// taken.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   pc_in        in   current PC value from the PC register
//   stall        in   ID stage cannot accept; IF/ID holds
//   flush        in   branch/jump redirect this cycle; squash the fetch path
//   hold_pc      out  0 = PC may update this cycle
//   imem_req     out  one-cycle request pulse
//   imem_addr    out  request address, meaningful while imem_req=1
//   imem_ack     in   response valid (at least one cycle after the request)
//   imem_rdata   in   instruction word, valid with imem_ack
//   id_valid     out  IF/ID holds a real instruction
//   id_instr     out  IF/ID instruction (NOP_INSTR while id_valid=0)
//   id_pc        out  address of id_instr
//   id_pc_plus4  out  id_pc + 4, modulo 2^32
//   fetch_err    out  sticky flag: a memory response timed out
//
// Parameters
//   NOP_INSTR    instruction word presented while IF/ID holds a bubble
//   TIMEOUT      response cycles waited before the request is reissued;
//                0 disables the timeout
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  output logic        hold_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_err
);

  // Counter is wide enough to hold TIMEOUT itself (it saturates there) and
  // stays at least one bit wide when the timeout is disabled.
  localparam int CW = $clog2(TIMEOUT + 2);

  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);
  // Last counter value seen in a waiting cycle before the timeout fires; the
  // timeout therefore triggers in the TIMEOUT-th waiting cycle.
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q,       state_d;
  logic [31:0]     req_pc_q,      req_pc_d;
  logic [CW-1:0]   wait_cnt_q,    wait_cnt_d;
  logic [31:0]     skid_data_q,   skid_data_d;
  logic            skid_valid_q,  skid_valid_d;
  logic            fetch_err_q,   fetch_err_d;
  logic            id_valid_q,    id_valid_d;
  logic [31:0]     id_instr_q,    id_instr_d;
  logic [31:0]     id_pc_q,       id_pc_d;
  logic [31:0]     id_pc_plus4_q, id_pc_plus4_d;

  // Per-cycle control decoded by the FSM
  logic            deliver;        // an instruction enters IF/ID this cycle
  logic [31:0]     deliver_instr;  // word that enters IF/ID when deliver=1
  logic            timeout_hit;    // this waiting cycle is the last allowed
  logic [CW-1:0]   wait_cnt_inc;   // saturating increment of the counter

  always_comb begin
    timeout_hit  = (TIMEOUT != 0) && (wait_cnt_q == TMO_LAST);
    wait_cnt_inc = (wait_cnt_q == TMO_MAX) ? wait_cnt_q : wait_cnt_q + CW'(1);
  end

  // ---------------------------------------------------------------------------
  // FSM next state and request side
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    wait_cnt_d    = wait_cnt_q;
    skid_data_d   = skid_data_q;
    skid_valid_d  = skid_valid_q;
    fetch_err_d   = fetch_err_q;
    deliver       = 1'b0;
    deliver_instr = skid_data_q;
    imem_req      = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        // Request goes out unconditionally; on a flush its response is
        // simply discarded, which keeps the one-outstanding rule intact.
        imem_req   = 1'b1;
        req_pc_d   = pc_in;
        wait_cnt_d = '0;
        state_d    = flush ? ST_DISCARD : ST_WAIT;
      end

      ST_WAIT: begin
        wait_cnt_d = wait_cnt_inc;
        if (flush) begin
          if (imem_ack) begin
            state_d = ST_FETCH;
          end else begin
            // The response is still in flight: drain it before reissuing.
            wait_cnt_d = '0;
            state_d    = ST_DISCARD;
          end
        end else if (imem_ack) begin
          if (!stall) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            state_d       = ST_FETCH;
          end else begin
            // ID cannot take it: park the word so memory is not re-read.
            skid_data_d  = imem_rdata;
            skid_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end else if (timeout_hit) begin
          fetch_err_d = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (flush) begin
          skid_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (!stall) begin
          deliver       = skid_valid_q;
          deliver_instr = skid_data_q;
          skid_valid_d  = 1'b0;
          state_d       = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        wait_cnt_d = wait_cnt_inc;
        if (imem_ack) begin
          state_d = ST_FETCH;
        end else if (timeout_hit) begin
          fetch_err_d = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // IF/ID register update: flush > stall > deliver > bubble
  // ---------------------------------------------------------------------------
  always_comb begin
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;

    if (flush) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end else if (stall) begin
      // hold every field
    end else if (deliver) begin
      id_valid_d    = 1'b1;
      id_instr_d    = deliver_instr;
      id_pc_d       = req_pc_q;
      id_pc_plus4_d = req_pc_q + 32'd4;  // wraps naturally at 32 bits
    end else begin
      // Bubble: the PC fields keep their last value.
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FETCH;
      req_pc_q      <= '0;
      wait_cnt_q    <= '0;
      skid_data_q   <= '0;
      skid_valid_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      wait_cnt_q    <= wait_cnt_d;
      skid_data_q   <= skid_data_d;
      skid_valid_q  <= skid_valid_d;
      fetch_err_q   <= fetch_err_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The PC moves exactly once per instruction that IF/ID consumes, and may
  // always take a redirect target on flush.
  assign hold_pc     = ~(deliver | flush);
  assign imem_addr   = pc_in;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The bench plays the PC register (advances on
// hold_pc=0, takes a redirect target on flush) and an instruction memory with
// programmable latency whose word for address A is {16'hC0DE, A[15:0]}.
// Expected request addresses and IF/ID loads are queued by the stimulus; a
// monitor pops and compares them whenever the DUT issues a request or loads
// IF/ID. The main sequence additionally checks cycle-specific values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        hold_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_err;

  fetch_unit #(
    .NOP_INSTR (NOP),
    .TIMEOUT   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .stall       (stall),
    .flush       (flush),
    .hold_pc     (hold_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_q[$];

  int          mem_lat = 1;   // 0 = never answer
  logic [31:0] redir = '0;

  // Values seen during the cycle most recently completed by cyc()
  logic        s_hold, s_req, s_valid, s_err;
  logic [31:0] s_addr, s_instr, s_pc, s_pcp4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] p, input logic [31:0] q);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    e.pcp4  = q;
    exp_q.push_back(e);
  endtask

  // One clock cycle: sample outputs mid-cycle, then act as the PC register.
  task automatic cyc();
    @(negedge clk);
    s_hold  = hold_pc;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = id_valid;
    s_instr = id_instr;
    s_pc    = id_pc;
    s_pcp4  = id_pc_plus4;
    s_err   = fetch_err;
    @(posedge clk);
    #1;
    if (rst && !s_hold) pc_in = flush ? redir : pc_in + 32'd4;
  endtask

  // ---------------------------------------------------------------------------
  // Instruction memory model
  // ---------------------------------------------------------------------------
  initial begin : memory
    logic        req_s, rst_s, mp;
    logic [31:0] addr_s, ma;
    int          lat_s, mc;
    mp = 1'b0;
    mc = 0;
    ma = '0;
    forever begin
      @(negedge clk);
      req_s  = imem_req;
      addr_s = imem_addr;
      lat_s  = mem_lat;
      rst_s  = rst;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (!rst_s) begin
        mp         = 1'b0;
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end else begin
        if (req_s) begin
          mp = (lat_s != 0);
          mc = lat_s;
          ma = addr_s;
        end
        if (mp) begin
          mc--;
          if (mc == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = {16'hC0DE, ma[15:0]};
            mp         = 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic load_pend;
    exp_t e;
    load_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (load_pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got pc %08h instr %08h expected no load", id_pc, id_instr);
        end else begin
          e = exp_q.pop_front();
          $display("LOAD pc=%08h pc4=%08h instr=%08h valid=%0b", id_pc, id_pc_plus4, id_instr, id_valid);
          chk("load_valid", 32'(id_valid), 32'd1);
          chk("load_instr", id_instr, e.instr);
          chk("load_pc", id_pc, e.pc);
          chk("load_pc_plus4", id_pc_plus4, e.pcp4);
        end
      end
      load_pend = rst && !hold_pc && !flush;
      if (rst && imem_req) begin
        $display("REQ addr=%08h", imem_addr);
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %08h expected no request", imem_addr);
        end else begin
          chk("req_addr", imem_addr, req_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    // Reset held for 3 cycles with random inputs (flush kept low)
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_in = $urandom;
      stall = 1'($urandom_range(0, 1));
      cyc();
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_instr", s_instr, NOP);
      chk("rst_hold", 32'(s_hold), 32'd1);
      chk("rst_req", 32'(s_req), 32'd1);
      chk("rst_err", 32'(s_err), 32'd0);
      chk("rst_pc", s_pc, 32'd0);
    end

    // Test 1: basic fetch, 1-cycle memory
    pc_in = '0;
    stall = 1'b0;
    rst   = 1'b1;
    req_q.push_back(32'h0000_0000);
    req_q.push_back(32'h0000_0004);
    req_q.push_back(32'h0000_0008);
    push_exp(32'hC0DE_0000, 32'h0000_0000, 32'h0000_0004);
    push_exp(32'hC0DE_0004, 32'h0000_0004, 32'h0000_0008);
    push_exp(32'hC0DE_0008, 32'h0000_0008, 32'h0000_000C);
    cyc();  // FETCH
    chk("t1_fetch_hold", 32'(s_hold), 32'd1);
    chk("t1_fetch_addr", s_addr, 32'h0000_0000);
    cyc();  // WAIT + load
    chk("t1_load_hold", 32'(s_hold), 32'd0);
    cyc();
    chk("t1_after_valid", 32'(s_valid), 32'd1);
    cyc();
    cyc();
    cyc();

    // Test 2: ack during a 3-cycle stall goes through the skid buffer
    stall = 1'b1;
    req_q.push_back(32'h0000_000C);
    push_exp(32'hC0DE_000C, 32'h0000_000C, 32'h0000_0010);
    cyc();  // FETCH under stall
    for (int i = 0; i < 3; i++) begin
      cyc();  // WAIT(ack) then HOLD, HOLD
      chk("t2_stall_hold", 32'(s_hold), 32'd1);
      chk("t2_stall_valid", 32'(s_valid), 32'd1);
      chk("t2_stall_instr", s_instr, 32'hC0DE_0008);
      chk("t2_stall_pc", s_pc, 32'h0000_0008);
    end
    stall = 1'b0;
    cyc();  // HOLD releases
    chk("t2_release_hold", 32'(s_hold), 32'd0);

    // Test 3: flush in WAIT with a 3-cycle memory; late ack dropped
    mem_lat = 3;
    req_q.push_back(32'h0000_0010);
    req_q.push_back(32'h0000_0040);
    push_exp(32'hC0DE_0040, 32'h0000_0040, 32'h0000_0044);
    cyc();  // FETCH 0x10
    cyc();  // WAIT
    flush = 1'b1;
    redir = 32'h0000_0040;
    cyc();  // WAIT + flush
    chk("t3_flush_hold", 32'(s_hold), 32'd0);
    flush   = 1'b0;
    mem_lat = 1;
    cyc();  // DISCARD, late ack arrives
    chk("t3_discard_hold", 32'(s_hold), 32'd1);
    chk("t3_bubble_valid", 32'(s_valid), 32'd0);
    chk("t3_bubble_instr", s_instr, NOP);
    cyc();  // FETCH new target
    chk("t3_new_addr", s_addr, 32'h0000_0040);
    cyc();  // load

    // Test 4: flush together with stall and ack
    stall = 1'b1;
    req_q.push_back(32'h0000_0044);
    req_q.push_back(32'h0000_0080);
    push_exp(32'hC0DE_0080, 32'h0000_0080, 32'h0000_0084);
    cyc();  // FETCH under stall
    flush = 1'b1;
    redir = 32'h0000_0080;
    cyc();  // WAIT: ack + stall + flush
    chk("t4_flush_hold", 32'(s_hold), 32'd0);
    chk("t4_held_valid", 32'(s_valid), 32'd1);
    chk("t4_held_instr", s_instr, 32'hC0DE_0040);
    flush = 1'b0;
    stall = 1'b0;
    cyc();  // FETCH
    chk("t4_bubble_valid", 32'(s_valid), 32'd0);
    chk("t4_bubble_instr", s_instr, NOP);
    chk("t4_fetch_req", 32'(s_req), 32'd1);
    cyc();  // load

    // Test 5: timeout (TIMEOUT=4), memory silent
    mem_lat = 0;
    req_q.push_back(32'h0000_0084);
    req_q.push_back(32'h0000_0084);
    push_exp(32'hC0DE_0084, 32'h0000_0084, 32'h0000_0088);
    cyc();  // FETCH
    for (int i = 0; i < 4; i++) begin
      cyc();  // WAIT x4
      chk("t5_wait_hold", 32'(s_hold), 32'd1);
      chk("t5_wait_req", 32'(s_req), 32'd0);
      chk("t5_err_before", 32'(s_err), 32'd0);
    end
    mem_lat = 1;
    cyc();  // reissue
    chk("t5_err_set", 32'(s_err), 32'd1);
    chk("t5_reissue_addr", s_addr, 32'h0000_0084);
    cyc();  // load

    // Test 6: flush in FETCH, then pc+4 wrap-around
    flush = 1'b1;
    redir = 32'hFFFF_FFFC;
    req_q.push_back(32'h0000_0088);
    req_q.push_back(32'hFFFF_FFFC);
    req_q.push_back(32'h0000_0000);
    req_q.push_back(32'h0000_0004);
    push_exp(32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
    push_exp(32'hC0DE_0000, 32'h0000_0000, 32'h0000_0004);
    cyc();  // FETCH + flush
    chk("t6_flush_hold", 32'(s_hold), 32'd0);
    chk("t6_err_sticky", 32'(s_err), 32'd1);
    flush = 1'b0;
    cyc();  // DISCARD drops ack
    chk("t6_discard_hold", 32'(s_hold), 32'd1);
    cyc();  // FETCH 0xFFFFFFFC
    chk("t6_wrap_addr", s_addr, 32'hFFFF_FFFC);
    cyc();  // load
    cyc();  // FETCH 0
    chk("t6_wrap_pc", s_pc, 32'hFFFF_FFFC);
    chk("t6_wrap_pc_plus4", s_pcp4, 32'h0000_0000);
    cyc();  // load
    cyc();  // FETCH 4
    chk("t6_err_sticky2", 32'(s_err), 32'd1);

    // Reset again clears the sticky error
    rst = 1'b0;
    cyc();
    chk("rst2_err", 32'(s_err), 32'd0);
    chk("rst2_valid", 32'(s_valid), 32'd0);
    chk("rst2_instr", s_instr, NOP);

    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("load_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1);
  end

endmodule
